// File: rtl/clk_div_pkg.sv
// Shared types, defaults and helpers for the clock divider bank.
// Divider half-period is BASE_HALF shifted left by the per-channel select.
package clk_div_pkg;

    localparam int unsigned DEF_SEL_W     = 3;
    localparam int unsigned DEF_BASE_HALF = 5000000;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic logic [63:0] half_of(input logic [63:0] base,
                                            input logic [7:0]  sel);
        return base << sel;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: run/idle FSM, half-period counter, pending rate
// select that is only applied at a half-period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SEL_W     = DEF_SEL_W,
    parameter int unsigned BASE_HALF = DEF_BASE_HALF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic [SEL_W-1:0] prog_o,
    output logic             pend_o
);

    localparam logic [63:0] MAX_HALF =
        half_of(64'(BASE_HALF), 8'((1 << SEL_W) - 1));
    localparam logic [CNT_W-1:0] HALF0 = CNT_W'(BASE_HALF);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    if ((MAX_HALF >> CNT_W) != 64'd0) begin : g_ovf
        $error("clk_div_chan: BASE_HALF << max sel overflows CNT_W");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] psel_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] half_d;
    logic             last;

    assign half_d = CNT_W'(half_of(64'(BASE_HALF), 8'(psel_q)));
    assign last   = (cnt_q == half_q - ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= HALF0;
            sel_q   <= '0;
            psel_q  <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    clk_q <= 1'b0;
                    cnt_q <= '0;
                    if (pend_q) begin
                        half_q <= half_d;
                        sel_q  <= psel_q;
                        pend_q <= 1'b0;
                    end
                    if (en_i) state_q <= RUN;
                end
                RUN: begin
                    if (last) begin
                        cnt_q <= '0;
                        if (pend_q) begin
                            half_q <= half_d;
                            sel_q  <= psel_q;
                            pend_q <= 1'b0;
                        end
                        if (!en_i && !clk_q) begin
                            state_q <= IDLE;
                        end else begin
                            clk_q  <= ~clk_q;
                            tick_q <= ~clk_q;
                        end
                    end else if (!en_i && !clk_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A write on a boundary edge lands after the apply above.
            if (wr_i) begin
                psel_q <= sel_i;
                pend_q <= 1'b1;
            end
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign prog_o = sel_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock dividers.
// Holds only the program-strobe decode and per-channel output packing.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SEL_W     = DEF_SEL_W,
    parameter int unsigned BASE_HALF = DEF_BASE_HALF,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  update,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [SEL_W-1:0]      prog_in,
    input  logic [N_CH-1:0]       en,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick_out,
    output logic [N_CH*SEL_W-1:0] prog_out,
    output logic [N_CH-1:0]       pending
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic wr;
        // Addresses beyond N_CH-1 match no channel and are dropped.
        assign wr = update && (ch_sel == CH_W'(k));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .SEL_W    (SEL_W),
            .BASE_HALF(BASE_HALF)
        ) u_chan (
            .clk_i (clock),
            .rst_i (reset),
            .wr_i  (wr),
            .sel_i (prog_in),
            .en_i  (en[k]),
            .clk_o (clk_out[k]),
            .tick_o(tick_out[k]),
            .prog_o(prog_out[k*SEL_W +: SEL_W]),
            .pend_o(pending[k])
        );
    end

endmodule
